// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: parametrised VGA timing, scaled framebuffer fetch and colour-bar output.
// Ports: clk/rst (async, active high), pix_en strobe, enable, test_pattern,
//        fb_rd/fb_addr/fb_data framebuffer read port, red/green/blue, hsync, vsync, frame_start.
module vga_pixel_pipe #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int COLOR_W     = 5,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  input  logic                 enable,
  input  logic                 test_pattern,
  output logic                 fb_rd,
  output logic [ADDR_W-1:0]    fb_addr,
  input  logic [3*COLOR_W-1:0] fb_data,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start
);

  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL + 1);
  localparam int VC_W    = $clog2(V_TOTAL + 1);
  localparam int BAR_LEN = H_ACTIVE / 8;
  localparam int BC_W    = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

  localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_LAST_C = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] HS_BEG_C = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END_C = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_LAST_C = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] VS_BEG_C = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END_C = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W-1:0] V_MASK_C = VC_W'((1 << SCALE_SHIFT) - 1);
  localparam logic [BC_W-1:0] BC_LAST_C = BC_W'(BAR_LEN - 1);
  localparam logic [ADDR_W-1:0] FB_W_C  = ADDR_W'(FB_W);

  logic [HC_W-1:0]   r_h;
  logic [VC_W-1:0]   r_v;
  logic [ADDR_W-1:0] r_row_base;
  logic [BC_W-1:0]   r_bar_cnt;
  logic [2:0]        r_bar;

  logic              r_fb_rd;
  logic [ADDR_W-1:0] r_fb_addr;

  logic              r_p_active;
  logic [2:0]        r_p_bar;
  logic              r_p_hs;
  logic              r_p_vs;
  logic              r_p_first;

  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_green;
  logic [COLOR_W-1:0] r_blue;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_frame_start;

  logic              w_active;
  logic              w_hs;
  logic              w_vs;
  logic              w_h_last;
  logic              w_v_last;
  logic [VC_W-1:0]   w_v_next;
  logic              w_row_step;
  logic [ADDR_W-1:0] w_addr;

  assign w_active = (r_h < H_ACT_C) && (r_v < V_ACT_C);
  assign w_hs     = (r_h >= HS_BEG_C) && (r_h < HS_END_C);
  assign w_vs     = (r_v >= VS_BEG_C) && (r_v < VS_END_C);
  assign w_h_last = (r_h == H_LAST_C);
  assign w_v_last = (r_v == V_LAST_C);
  assign w_v_next = r_v + VC_W'(1);
  // next line starts a new framebuffer row when its low scale bits are zero
  assign w_row_step = ((w_v_next & V_MASK_C) == '0);
  assign w_addr   = r_row_base + ADDR_W'(r_h >> SCALE_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h           <= '0;
      r_v           <= '0;
      r_row_base    <= '0;
      r_bar_cnt     <= '0;
      r_bar         <= '0;
      r_fb_rd       <= 1'b0;
      r_fb_addr     <= '0;
      r_p_active    <= 1'b0;
      r_p_bar       <= '0;
      r_p_hs        <= 1'b0;
      r_p_vs        <= 1'b0;
      r_p_first     <= 1'b0;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_fb_rd       <= 1'b0;
      r_frame_start <= 1'b0;
      if (pix_en) begin
        // stage 0: request the pixel, capture its attributes
        r_fb_rd <= w_active;
        if (w_active) begin
          r_fb_addr <= w_addr;
        end
        r_p_active <= w_active;
        r_p_bar    <= r_bar;
        r_p_hs     <= w_hs;
        r_p_vs     <= w_vs;
        r_p_first  <= (r_h == '0) && (r_v == '0);

        // stage 1: present the pixel captured on the previous strobe
        r_frame_start <= r_p_first;
        r_hsync <= r_p_hs ? HSYNC_POL : ~HSYNC_POL;
        r_vsync <= r_p_vs ? VSYNC_POL : ~VSYNC_POL;
        if (!r_p_active || !enable) begin
          r_red   <= '0;
          r_green <= '0;
          r_blue  <= '0;
        end else if (test_pattern) begin
          r_red   <= {COLOR_W{r_p_bar[2]}};
          r_green <= {COLOR_W{r_p_bar[1]}};
          r_blue  <= {COLOR_W{r_p_bar[0]}};
        end else begin
          r_red   <= fb_data[3*COLOR_W-1:2*COLOR_W];
          r_green <= fb_data[2*COLOR_W-1:COLOR_W];
          r_blue  <= fb_data[COLOR_W-1:0];
        end

        // counters
        if (w_h_last) begin
          r_h       <= '0;
          r_bar_cnt <= '0;
          r_bar     <= '0;
          if (w_v_last) begin
            r_v        <= '0;
            r_row_base <= '0;
          end else begin
            r_v <= w_v_next;
            if (w_row_step) begin
              r_row_base <= r_row_base + FB_W_C;
            end
          end
        end else begin
          r_h <= r_h + HC_W'(1);
          // bar index past the active area is never displayed
          if (r_bar_cnt == BC_LAST_C) begin
            r_bar_cnt <= '0;
            r_bar     <= r_bar + 3'd1;
          end else begin
            r_bar_cnt <= r_bar_cnt + BC_W'(1);
          end
        end
      end
    end
  end

  assign fb_rd       = r_fb_rd;
  assign fb_addr     = r_fb_addr;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb_vga_pixel_pipe: directed bench for vga_pixel_pipe with a scoreboard of expected pixels.
// Uses a reduced timing set so whole frames fit in a short run.
module tb_vga_pixel_pipe;

  localparam int H_ACTIVE = 64;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 4;
  localparam int V_ACTIVE = 16;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W     = H_ACTIVE >> 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic        enable;
  logic        test_pattern;
  logic        fb_rd;
  logic [14:0] fb_addr;
  logic [14:0] fb_data = '0;
  logic [4:0]  red;
  logic [4:0]  green;
  logic [4:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  vga_pixel_pipe #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .COLOR_W(5), .SCALE_SHIFT(2), .ADDR_W(15)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .enable(enable),
    .test_pattern(test_pattern), .fb_rd(fb_rd), .fb_addr(fb_addr),
    .fb_data(fb_data), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // framebuffer ram: returns its own address, or all ones when forced
  bit ram_force;
  always @(posedge clk) begin
    if (fb_rd) fb_data <= ram_force ? 15'h7FFF : fb_addr;
  end

  typedef struct {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
    logic       hs;
    logic       vs;
    logic       fs;
  } exp_t;

  exp_t        sb[$];
  int          n_assert;
  int          n_fail;
  int          mh, mv, ph, pv;
  bit          have_prev;
  logic [14:0] pfb;
  logic [14:0] last_addr;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int h, input int v,
                                 input logic [14:0] fbw,
                                 input logic en, input logic tp);
    exp_t     e;
    bit       act;
    bit [2:0] bb;
    act  = (h < H_ACTIVE) && (v < V_ACTIVE);
    bb   = 3'(h / (H_ACTIVE / 8));
    e.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? 1'b0 : 1'b1;
    e.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? 1'b0 : 1'b1;
    e.fs = (h == 0) && (v == 0);
    if (!act || !en) begin
      e.r = '0; e.g = '0; e.b = '0;
    end else if (tp) begin
      e.r = {5{bb[2]}}; e.g = {5{bb[1]}}; e.b = {5{bb[0]}};
    end else begin
      e.r = fbw[14:10]; e.g = fbw[9:5]; e.b = fbw[4:0];
    end
    return e;
  endfunction

  task automatic check_reset();
    check("rst_red", 32'(red), 32'd0);
    check("rst_green", 32'(green), 32'd0);
    check("rst_blue", 32'(blue), 32'd0);
    check("rst_fb_rd", 32'(fb_rd), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_frame_start", 32'(frame_start), 32'd0);
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; have_prev = 0;
    last_addr = '0;
    sb.delete();
  endtask

  // one pixel strobe, 2 clk period; called at a negedge
  task automatic strobe();
    exp_t e;
    bit   act;
    act = (mh < H_ACTIVE) && (mv < V_ACTIVE);
    if (have_prev) begin
      e = model(ph, pv, pfb, enable, test_pattern);
      sb.push_back(e);
    end
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    check("fb_rd", 32'(fb_rd), 32'(act));
    if (act) last_addr = 15'((mv >> 2) * FB_W + (mh >> 2));
    check("fb_addr", 32'(fb_addr), 32'(last_addr));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("red", 32'(red), 32'(e.r));
      check("green", 32'(green), 32'(e.g));
      check("blue", 32'(blue), 32'(e.b));
      check("hsync", 32'(hsync), 32'(e.hs));
      check("vsync", 32'(vsync), 32'(e.vs));
      check("frame_start", 32'(frame_start), 32'(e.fs));
    end
    pfb = ram_force ? 15'h7FFF : last_addr;
    ph = mh; pv = mv; have_prev = 1;
    if (mh == H_TOTAL - 1) begin
      mh = 0;
      mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    @(negedge clk);
    check("fb_rd_pulse", 32'(fb_rd), 32'd0);
    check("fs_pulse", 32'(frame_start), 32'd0);
  endtask

  logic [4:0]  s_r, s_g, s_b;
  logic        s_hs, s_vs;
  logic [14:0] s_addr;

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1; pix_en = 1'b0; enable = 1'b1;
    test_pattern = 1'b0; ram_force = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);

    // more than one frame of framebuffer data
    repeat (H_TOTAL * V_TOTAL + 10) strobe();

    // colour bars for a full line
    test_pattern = 1'b1;
    repeat (H_TOTAL) strobe();
    test_pattern = 1'b0;

    // all-ones framebuffer, blanked then enabled
    ram_force = 1'b1;
    enable = 1'b0;
    repeat (2 * H_TOTAL) strobe();
    enable = 1'b1;
    repeat (H_TOTAL) strobe();
    ram_force = 1'b0;

    // freeze mid-line
    repeat (30) strobe();
    s_r = red; s_g = green; s_b = blue;
    s_hs = hsync; s_vs = vsync; s_addr = fb_addr;
    repeat (100) @(negedge clk);
    check("frz_red", 32'(red), 32'(s_r));
    check("frz_green", 32'(green), 32'(s_g));
    check("frz_blue", 32'(blue), 32'(s_b));
    check("frz_hsync", 32'(hsync), 32'(s_hs));
    check("frz_vsync", 32'(vsync), 32'(s_vs));
    check("frz_fb_addr", 32'(fb_addr), 32'(s_addr));
    check("frz_fb_rd", 32'(fb_rd), 32'd0);
    repeat (100) strobe();

    // asynchronous reset mid-line
    test_pattern = 1'b1;
    repeat (20) strobe();
    #2 rst = 1'b1;
    #1 check_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (3 * H_TOTAL) strobe();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
